gray_code_counter: RTL
======================

// Module: gray_code_counter
//
// PURPOSE
//   Registered up/down binary counter with a registered Gray-code output. The
//   binary count is produced, then converted with gray = bin ^ (bin >> 1).
//   Downstream logic gets a glitch-free Gray sequence in which one bit changes
//   per step. Intended uses: pointer generation, position sequencing, and
//   stimulus for Gray-code consumers.
//
// PARAMETERS
//   WIDTH  4  counter/code width in bits; count range 0 .. 2**WIDTH-1 (power-of-2 modulus only)
//
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      count enable; one step per cycle while high
//   up_dn     in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      synchronous load of load_val; overrides en
//   load_val  in   WIDTH  binary value to load
//   bin_out   out  WIDTH  registered binary count
//   gray_out  out  WIDTH  registered Gray code of bin_out (same-cycle aligned)
//   wrap      out  1      one-cycle pulse: count wrapped max->0 (up) or 0->max (down)
//   changed   out  1      one-cycle pulse: bin_out/gray_out updated this cycle
//
// BEHAVIOUR
//   - Reset (rst_n low, async): bin_out=0, gray_out=0, wrap=0, changed=0.
//     Outputs hold these values while rst_n is low. Counting resumes on the
//     first rising clk edge after release.
//   - Priority per clk edge: load > en > hold.
//     - load=1: bin_next = load_val, regardless of en/up_dn.
//       wrap=0. changed=1 only if load_val != bin_out.
//     - load=0, en=1, up_dn=1: bin_next = bin_out + 1 mod 2**WIDTH.
//     - load=0, en=1, up_dn=0: bin_next = bin_out - 1 mod 2**WIDTH.
//     - load=0, en=0: hold all count state. wrap=0, changed=0.
//   - gray_out is registered from bin_next on the same edge as bin_out.
//     Latency from control inputs to both outputs is 1 cycle. There is never a
//     cycle where gray_out and bin_out disagree.
//   - wrap=1 only on a counting step:
//     - up from 2**WIDTH-1 to 0, or
//     - down from 0 to 2**WIDTH-1.
//     A load to 0 or to max never asserts wrap.
//   - changed=1 on every counting step, and on a load that alters the value.
//   - Invariant: on a counting step, gray_out differs from its previous value
//     in exactly one bit, including across wrap. A load may change multiple bits.
//   - up_dn may change every cycle. Each step uses the up_dn sampled on that edge.
//   - Arithmetic is unsigned WIDTH-bit. There is no saturation; all overflow wraps.
//   - No internal state beyond the bin/gray/wrap/changed registers. No FSM is needed.
//
// TESTING   (WIDTH=4)
//   1. Reset: assert rst_n=0 mid-count at bin_out=9.
//      -> bin_out=0, gray_out=0, wrap=0 immediately (async, no clk edge).
//   2. Full up-count: en=1, up_dn=1 for 16 cycles from 0.
//      -> gray_out = 0000,0001,0011,0010,0110,...,1000 then 0000.
//         wrap=1 only on the 15->0 step.
//         Every step shows Hamming distance 1.
//   3. Down-count across zero: load 1, then en=1, up_dn=0 for 3 cycles.
//      -> bin_out 1,0,15,14.
//         gray_out 0001,0000,1000,1001.
//         wrap=1 on the 0->15 step only.
//   4. Load priority: load=1, load_val=4'b1010, en=1 simultaneously.
//      -> next bin_out=10, gray_out=1111, wrap=0, changed=1.
//         A repeated load of 10 gives changed=0.
//   5. Hold: en=0, load=0 for 5 cycles at bin_out=6.
//      -> bin_out=6, gray_out=0101 throughout; changed=0, wrap=0.
//   6. Direction toggle every cycle from 7 (up,down,up,down).
//      -> bin_out 8,7,8,7; gray_out 1100,0100,1100,0100; wrap never set.

Source files
------------

// File: rtl/gray_code_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_code_counter
//  Description : Registered up/down binary counter with a registered Gray-code
//                output aligned to the same edge. It also produces one-cycle
//                wrap and changed pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             changed
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max  = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_changed;

  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic             w_changed_next;

  // Next-count selection: load beats enable, enable beats hold.
  // Both wrap directions come from ordinary modular arithmetic.
  always_comb begin
    w_bin_next     = r_bin;
    w_wrap_next    = 1'b0;
    w_changed_next = 1'b0;
    if (load) begin
      w_bin_next     = load_val;
      w_changed_next = (load_val != r_bin);
    end else if (en) begin
      w_changed_next = 1'b1;
      if (up_dn) begin
        w_bin_next  = r_bin + c_one;
        w_wrap_next = (r_bin == c_max);
      end else begin
        w_bin_next  = r_bin - c_one;
        w_wrap_next = (r_bin == c_zero);
      end
    end
  end

  // Gray encoding is taken from the next binary value.
  // The two registered codes therefore never disagree.
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Count, code and pulse registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= c_zero;
      r_gray    <= c_zero;
      r_wrap    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_bin     <= w_bin_next;
      r_gray    <= w_gray_next;
      r_wrap    <= w_wrap_next;
      r_changed <= w_changed_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  assign changed  = r_changed;

endmodule
`default_nettype wire
